weight_load_sequencer: RTL

Streams a flat, pre-ordered weight image into every per-neuron weight memory controller in the network. It accepts 32-bit padded weight words over a valid/ready stream. It drives the shared config bus (weight_valid, weight_value, config_layer_no, config_neuron_no) so that each neuron's controller captures only its own weights. It sits between the host/DMA loader and all neuron instances, and sequences the whole load layer-major, then neuron, then weight.

---
 rtl/weight_load_sequencer_pkg.sv | 34 +++
 rtl/weight_load_sequencer_load_index_counter.sv | 85 ++++++++
 rtl/weight_load_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/weight_load_sequencer_pkg.sv
// weight_load_pkg: shared FSM state encoding, counter index types sized for the
// largest supported network, and the per-layer weights-per-neuron helper.
package weight_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest network the index counters are sized for.
    localparam int unsigned MAX_NEURONS_CAP = 1023;
    localparam int unsigned NUM_INPUTS_CAP  = 784;

    localparam int unsigned NEURON_W = $clog2(MAX_NEURONS_CAP + 1);
    localparam int unsigned INPUT_W  = $clog2(NUM_INPUTS_CAP + 1);
    // A neuron in layer L>0 takes one weight per neuron of layer L-1, so the
    // weight index must cover both the input count and the neuron count.
    localparam int unsigned WEIGHT_W = (INPUT_W > NEURON_W) ? INPUT_W : NEURON_W;
    localparam int unsigned LAYER_W  = 8;

    typedef logic [NEURON_W-1:0] neuron_idx_t;
    typedef logic [WEIGHT_W-1:0] weight_idx_t;
    typedef logic [LAYER_W-1:0]  layer_idx_t;

    // Weights per neuron of a layer: the network input count for layer 0,
    // otherwise the neuron count of the previous layer.
    function automatic int unsigned wpn(input int unsigned layer,
                                        input int unsigned n_inputs,
                                        input int unsigned prev_neurons);
        return (layer == 0) ? n_inputs : prev_neurons;
    endfunction

endpackage

// File: rtl/weight_load_sequencer_load_index_counter.sv
// load_index_counter: nested weight -> neuron -> layer index counter that walks
// the weight image layer-major. o_last flags the final word of the image.
module load_index_counter
    import weight_load_pkg::*;
#(
    parameter int unsigned                       NUM_LAYERS    = 3,
    parameter int unsigned                       NUM_INPUTS    = 784,
    parameter logic [0:NUM_LAYERS-1][15:0]       LAYER_NEURONS = {16'd30, 16'd30, 16'd10}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_advance,
    output layer_idx_t  o_layer,
    output neuron_idx_t o_neuron,
    output logic        o_last
);

    weight_idx_t w_wlim [NUM_LAYERS];
    neuron_idx_t w_nlim [NUM_LAYERS];
    weight_idx_t w_wmax;
    neuron_idx_t w_nmax;
    logic        w_weight_wrap;
    logic        w_neuron_wrap;
    logic        w_layer_last;

    layer_idx_t  r_layer;
    neuron_idx_t r_neuron;
    weight_idx_t r_weight;

    // Per-layer wrap limits are elaboration constants.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_lim
            if (gi == 0) begin : g_first
                assign w_wlim[gi] = weight_idx_t'(wpn(0, NUM_INPUTS, 0) - 1);
            end else begin : g_rest
                assign w_wlim[gi] = weight_idx_t'(wpn(gi, NUM_INPUTS,
                                        int'(LAYER_NEURONS[gi-1])) - 1);
            end
            assign w_nlim[gi] = neuron_idx_t'(LAYER_NEURONS[gi] - 16'd1);
        end
    endgenerate

    // Select the wrap limits of the layer currently being loaded.
    always_comb begin
        w_wmax = '0;
        w_nmax = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (r_layer == layer_idx_t'(i)) begin
                w_wmax = w_wlim[i];
                w_nmax = w_nlim[i];
            end
        end
    end

    assign w_weight_wrap = (r_weight == w_wmax);
    assign w_neuron_wrap = w_weight_wrap && (r_neuron == w_nmax);
    assign w_layer_last  = (r_layer == layer_idx_t'(NUM_LAYERS - 1));
    assign o_last        = w_neuron_wrap && w_layer_last;
    assign o_layer       = r_layer;
    assign o_neuron      = r_neuron;

    // Advance the nested indices once per accepted word; clear on a new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer  <= '0;
            r_neuron <= '0;
            r_weight <= '0;
        end else if (i_clear) begin
            r_layer  <= '0;
            r_neuron <= '0;
            r_weight <= '0;
        end else if (i_advance) begin
            r_weight <= w_weight_wrap ? '0 : r_weight + weight_idx_t'(1);
            if (w_weight_wrap) begin
                r_neuron <= (r_neuron == w_nmax) ? '0 : r_neuron + neuron_idx_t'(1);
            end
            if (w_neuron_wrap && !w_layer_last) begin
                r_layer <= r_layer + layer_idx_t'(1);
            end
        end
    end

endmodule

// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer: streams a pre-ordered weight image from a valid/ready
// input onto the shared neuron config bus, one strobe per accepted word.
// Optional feature macro: WEIGHT_LOAD_CHECKSUM_EN adds a 32-bit checksum output.
module weight_load_sequencer
    import weight_load_pkg::*;
#(
    parameter int unsigned                 num_layers    = 3,
    parameter int unsigned                 num_inputs    = 784,
    parameter int unsigned                 max_neurons   = 1023,
    parameter logic [0:num_layers-1][15:0] layer_neurons = {16'd30, 16'd30, 16'd10},
    parameter int unsigned                 data_bits     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        weight_valid,
    output logic [31:0] weight_value,
    output logic [31:0] config_layer_no,
    output logic [31:0] config_neuron_no,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_count
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_clear;
    logic        w_accept;
    logic        w_last;
    layer_idx_t  w_layer;
    neuron_idx_t w_neuron;
    logic [31:0] w_masked;
    logic        w_unused_data;

    logic        r_weight_valid;
    logic [31:0] r_weight_value;
    logic [31:0] r_layer_no;
    logic [31:0] r_neuron_no;
    logic [31:0] r_load_count;

    // Configuration sanity checks resolved at elaboration.
    genvar gi;
    generate
        for (gi = 0; gi < num_layers; gi++) begin : g_chk
            if (layer_neurons[gi] == 16'd0) begin : g_zero
                $error("weight_load_sequencer: layer_neurons[%0d] is zero", gi);
            end
            if (int'(layer_neurons[gi]) > max_neurons) begin : g_big
                $error("weight_load_sequencer: layer_neurons[%0d] exceeds max_neurons", gi);
            end
        end
        if (max_neurons > MAX_NEURONS_CAP || num_inputs > NUM_INPUTS_CAP) begin : g_cap
            $error("weight_load_sequencer: network exceeds index counter widths");
        end
        if (data_bits == 0 || data_bits >= 32) begin : g_bits
            $error("weight_load_sequencer: data_bits must be in 1..31");
        end
    endgenerate

    assign w_masked      = {{(32 - data_bits){1'b0}}, s_data[data_bits-1:0]};
    assign w_unused_data = ^s_data[31:data_bits];

    // s_ready is a decode of the state register only, so it never depends on s_valid.
    assign s_ready  = (r_state == LOAD);
    assign busy     = (r_state == LOAD);
    assign done     = (r_state == DONE);
    // abort wins over a simultaneous handshake: the word is dropped.
    assign w_accept = s_valid && s_ready && !abort;

    load_index_counter #(
        .NUM_LAYERS    (num_layers),
        .NUM_INPUTS    (num_inputs),
        .LAYER_NEURONS (layer_neurons)
    ) u_index (
        .clk       (clk),
        .rst_n     (reset),
        .i_clear   (w_clear),
        .i_advance (w_accept),
        .o_layer   (w_layer),
        .o_neuron  (w_neuron),
        .o_last    (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a new load clears the index counters.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = LOAD;
                    w_clear      = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_accept && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Config-bus strobe one cycle after each accept; fields hold between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_weight_valid <= 1'b0;
            r_weight_value <= '0;
            r_layer_no     <= '0;
            r_neuron_no    <= '0;
            r_load_count   <= '0;
        end else begin
            r_weight_valid <= w_accept;
            if (w_accept) begin
                r_weight_value <= w_masked;
                r_layer_no     <= 32'(w_layer);
                r_neuron_no    <= 32'(w_neuron);
                r_load_count   <= r_load_count + 32'd1;
            end else if (w_clear) begin
                r_load_count   <= '0;
            end
        end
    end

    assign weight_valid     = r_weight_valid;
    assign weight_value     = r_weight_value;
    assign config_layer_no  = r_layer_no;
    assign config_neuron_no = r_neuron_no;
    assign load_count       = r_load_count;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Sum accepted words at accept time so the total already includes the final
    // word in the done cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if (w_clear) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + w_masked;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
